// File: rtl/imem_dmem_bus_arbiter.sv
// Three-way memory bus arbiter (dcache > icache > prefetch) with a tag-owner table for routing returns.
// Optional prefetch aging (promotes p over i after STARVE_LIMIT denials): define MEM_ARB_PREFETCH_AGE_EN.
module imem_dmem_bus_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        nuke,
  input  logic [1:0]  d_command,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_data,
  input  logic [1:0]  d_size,
  input  logic [1:0]  i_command,
  input  logic [63:0] i_addr,
  input  logic [1:0]  p_command,
  input  logic [63:0] p_addr,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [1:0]  proc2mem_size,
  output logic [3:0]  d_response,
  output logic [3:0]  i_response,
  output logic [3:0]  p_response,
  output logic        d_rd_valid,
  output logic        i_rd_valid,
  output logic        p_rd_valid,
  output logic [63:0] rd_data,
  output logic [3:0]  rd_tag,
  output logic [4:0]  outstanding_cnt
);

  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [1:0] BUS_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  localparam logic [1:0] OWN_D  = 2'd0;
  localparam logic [1:0] OWN_I  = 2'd1;
  localparam logic [1:0] OWN_P  = 2'd2;
  localparam logic [1:0] OWN_ST = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_D, GNT_I, GNT_P} grant_e;

  grant_e     grant;
  logic       d_req, i_req, p_req, p_promote, accept;
  logic [1:0] win_owner;
  logic [3:0] starve_cnt;

  assign d_req = (d_command != BUS_NONE);
  assign i_req = (i_command != BUS_NONE) && !nuke;
  assign p_req = (p_command != BUS_NONE) && !nuke;

  assign p_promote = (starve_cnt == STARVE_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (d_req)                  grant = GNT_D;
    else if (p_promote && p_req) grant = GNT_P;
    else if (i_req)             grant = GNT_I;
    else if (p_req)             grant = GNT_P;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    proc2mem_size    = 2'd0;
    win_owner        = OWN_D;
    case (grant)
      GNT_D: begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        proc2mem_data    = d_data;
        proc2mem_size    = d_size;
        win_owner        = (d_command == BUS_STORE) ? OWN_ST : OWN_D;
      end
      GNT_I: begin
        proc2mem_command = i_command;
        proc2mem_addr    = i_addr;
        proc2mem_size    = SIZE_DOUBLE;
        win_owner        = OWN_I;
      end
      GNT_P: begin
        proc2mem_command = p_command;
        proc2mem_addr    = p_addr;
        proc2mem_size    = SIZE_DOUBLE;
        win_owner        = OWN_P;
      end
      default: ;
    endcase
  end

  assign accept     = (grant != GNT_NONE) && (mem2proc_response != 4'd0);
  assign d_response = (grant == GNT_D) ? mem2proc_response : 4'd0;
  assign i_response = (grant == GNT_I) ? mem2proc_response : 4'd0;
  assign p_response = (grant == GNT_P) ? mem2proc_response : 4'd0;

`ifdef MEM_ARB_PREFETCH_AGE_EN
  logic [3:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if ((p_command == BUS_NONE) || (accept && (grant == GNT_P))) starve_d = 4'd0;
    else if (starve_q != STARVE_MAX)                             starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end

  assign starve_cnt = starve_q;
`else
  assign starve_cnt = 4'd0;
`endif

  logic [NUM_TAGS-1:0]      valid_q, valid_d, stale_q, stale_d;
  logic [NUM_TAGS-1:0][1:0] owner_q, owner_d;
  logic                     ret_hit, ret_live;
  logic [1:0]               ret_owner;

  assign ret_hit   = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
  assign ret_owner = owner_q[mem2proc_tag];
  assign ret_live  = ret_hit && !stale_q[mem2proc_tag] && (ret_owner != OWN_ST);

  // A set of the same tag in the cycle it returns overrides the clear.
  generate
    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
      logic set_e, clr_e, nuke_e;
      assign set_e  = accept && (mem2proc_response == 4'(gi));
      assign clr_e  = ret_hit && (mem2proc_tag == 4'(gi));
      assign nuke_e = nuke && valid_q[gi] && ((owner_q[gi] == OWN_I) || (owner_q[gi] == OWN_P));
      assign valid_d[gi] = set_e | (valid_q[gi] & ~clr_e);
      assign owner_d[gi] = set_e ? win_owner : owner_q[gi];
      assign stale_d[gi] = (set_e | clr_e) ? 1'b0 : (stale_q[gi] | nuke_e);
    end
  endgenerate

  logic [4:0] cnt_d;
  always_comb begin
    cnt_d = 5'd0;
    for (int k = 0; k < NUM_TAGS; k++) cnt_d = cnt_d + 5'(valid_d[k]);
  end

  logic        d_rd_valid_q, i_rd_valid_q, p_rd_valid_q;
  logic [63:0] rd_data_q;
  logic [3:0]  rd_tag_q;
  logic [4:0]  cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      stale_q      <= '0;
      owner_q      <= '0;
      d_rd_valid_q <= 1'b0;
      i_rd_valid_q <= 1'b0;
      p_rd_valid_q <= 1'b0;
      rd_data_q    <= 64'd0;
      rd_tag_q     <= 4'd0;
      cnt_q        <= 5'd0;
    end else begin
      valid_q      <= valid_d;
      stale_q      <= stale_d;
      owner_q      <= owner_d;
      d_rd_valid_q <= ret_live && (ret_owner == OWN_D);
      i_rd_valid_q <= ret_live && (ret_owner == OWN_I);
      p_rd_valid_q <= ret_live && (ret_owner == OWN_P);
      if (ret_live) begin
        rd_data_q <= mem2proc_data;
        rd_tag_q  <= mem2proc_tag;
      end
      cnt_q <= cnt_d;
    end
  end

  assign d_rd_valid      = d_rd_valid_q;
  assign i_rd_valid      = i_rd_valid_q;
  assign p_rd_valid      = p_rd_valid_q;
  assign rd_data         = rd_data_q;
  assign rd_tag          = rd_tag_q;
  assign outstanding_cnt = cnt_q;

endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// Directed bench for imem_dmem_bus_arbiter: stimulus pushes expected returns, a negedge monitor pops and checks them.
module tb_imem_dmem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        nuke;
  logic [1:0]  d_command, i_command, p_command, d_size;
  logic [63:0] d_addr, d_data, i_addr, p_addr, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [63:0] proc2mem_addr, proc2mem_data, rd_data;
  logic [3:0]  d_response, i_response, p_response, rd_tag;
  logic        d_rd_valid, i_rd_valid, p_rd_valid;
  logic [4:0]  outstanding_cnt;

  always #5 clock = ~clock;

  imem_dmem_bus_arbiter dut (
    .clock(clock), .reset(reset), .nuke(nuke),
    .d_command(d_command), .d_addr(d_addr), .d_data(d_data), .d_size(d_size),
    .i_command(i_command), .i_addr(i_addr),
    .p_command(p_command), .p_addr(p_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .d_response(d_response), .i_response(i_response), .p_response(p_response),
    .d_rd_valid(d_rd_valid), .i_rd_valid(i_rd_valid), .p_rd_valid(p_rd_valid),
    .rd_data(rd_data), .rd_tag(rd_tag), .outstanding_cnt(outstanding_cnt)
  );

  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam int K_D = 0, K_I = 1, K_P = 2;

`ifdef MEM_ARB_PREFETCH_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [63:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else
      $display("ok   %s = 0x%0h", name, act);
  endtask

  task automatic push(input int kind, input logic [63:0] data, input logic [3:0] tag);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    nuke = 0; d_command = NONE; i_command = NONE; p_command = NONE;
    d_addr = 0; d_data = 0; d_size = 0; i_addr = 0; p_addr = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
  endtask

  // Monitor: every delivered return must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    int   nv, kind;
    if (reset === 1'b1 && (d_rd_valid || i_rd_valid || p_rd_valid)) begin
      checks++;
      nv   = int'(d_rd_valid) + int'(i_rd_valid) + int'(p_rd_valid);
      kind = d_rd_valid ? K_D : (i_rd_valid ? K_I : K_P);
      if (nv > 1) begin
        errors++;
        $display("FAIL rd_valid_onehot: got %0d valids required 1", nv);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_return: got kind=%0d tag=%0d data=0x%0h required none", kind, rd_tag, rd_data);
      end else begin
        e = sb.pop_front();
        if (kind != e.kind || rd_data !== e.data || rd_tag !== e.tag) begin
          errors++;
          $display("FAIL return: got kind=%0d tag=%0d data=0x%0h required kind=%0d tag=%0d data=0x%0h",
                   kind, rd_tag, rd_data, e.kind, e.tag, e.data);
        end else
          $display("ok   return kind=%0d tag=%0d data=0x%0h", kind, rd_tag, rd_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_p;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_d_rd_valid", d_rd_valid, 0);
    chk("reset_i_rd_valid", i_rd_valid, 0);
    chk("reset_p_rd_valid", p_rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_tag", rd_tag, 0);
    chk("reset_outstanding", outstanding_cnt, 0);
    reset = 1'b1;
    step();

    // d beats i; load returns to d
    d_command = LOAD; d_addr = 64'h1000; i_command = LOAD; i_addr = 64'h2000; mem2proc_response = 3;
    #2;
    chk("t1_d_response", d_response, 3);
    chk("t1_i_response", i_response, 0);
    chk("t1_p_response", p_response, 0);
    chk("t1_bus_addr", proc2mem_addr, 64'h1000);
    chk("t1_bus_cmd", proc2mem_command, LOAD);
    step(); idle();
    chk("t1_outstanding_1", outstanding_cnt, 1);
    mem2proc_tag = 3; mem2proc_data = 64'hDEAD; push(K_D, 64'hDEAD, 3);
    step(); idle();
    chk("t1_outstanding_0", outstanding_cnt, 0);

    // i fetch made stale by nuke
    i_command = LOAD; i_addr = 64'h3000; mem2proc_response = 5;
    #2;
    chk("t2_i_response", i_response, 5);
    chk("t2_bus_size", proc2mem_size, 2'd3);
    chk("t2_bus_data", proc2mem_data, 0);
    chk("t2_bus_addr", proc2mem_addr, 64'h3000);
    step(); idle();
    chk("t2_outstanding_1", outstanding_cnt, 1);
    nuke = 1; i_command = LOAD; i_addr = 64'h3008; mem2proc_response = 6;
    #2;
    chk("t2_nuke_bus_cmd", proc2mem_command, NONE);
    chk("t2_nuke_i_response", i_response, 0);
    step(); idle();
    chk("t2_outstanding_after_nuke", outstanding_cnt, 1);
    mem2proc_tag = 5; mem2proc_data = 64'hBEEF;
    step(); idle();
    chk("t2_outstanding_0", outstanding_cnt, 0);

    // store consumed silently
    d_command = STORE; d_addr = 64'h4000; d_data = 64'h1234; d_size = 2; mem2proc_response = 7;
    #2;
    chk("t3_bus_cmd", proc2mem_command, STORE);
    chk("t3_bus_data", proc2mem_data, 64'h1234);
    chk("t3_bus_size", proc2mem_size, 2);
    chk("t3_d_response", d_response, 7);
    step(); idle();
    chk("t3_outstanding_1", outstanding_cnt, 1);
    mem2proc_tag = 7; mem2proc_data = 64'h77;
    step(); idle();
    chk("t3_outstanding_0", outstanding_cnt, 0);

    // p held through three rejects
    p_command = LOAD; p_addr = 64'h5000;
    for (int c = 0; c < 3; c++) begin
      mem2proc_response = 0;
      #2;
      chk("t4_p_rejected", p_response, 0);
      chk("t4_bus_addr", proc2mem_addr, 64'h5000);
      step();
    end
    mem2proc_response = 9;
    #2;
    chk("t4_p_response", p_response, 9);
    step(); idle();
    chk("t4_outstanding_1", outstanding_cnt, 1);
    mem2proc_tag = 9; mem2proc_data = 64'hCAFE; push(K_P, 64'hCAFE, 9);
    step(); idle();
    chk("t4_outstanding_0", outstanding_cnt, 0);

    // i and p held together; aging lets p through on the 9th cycle
    i_command = LOAD; i_addr = 64'h6000; p_command = LOAD; p_addr = 64'h7000;
    for (int c = 1; c <= 10; c++) begin
      mem2proc_response = 10;
      #2;
      exp_p = AGE && (c == 9);
      chk("t5_bus_addr", proc2mem_addr, exp_p ? 64'h7000 : 64'h6000);
      chk("t5_p_response", p_response, exp_p ? 64'd10 : 64'd0);
      step();
    end
    idle();
    chk("t5_outstanding_1", outstanding_cnt, 1);
    mem2proc_tag = 10; mem2proc_data = 64'hA0A0; push(K_I, 64'hA0A0, 10);
    step(); idle();
    chk("t5_outstanding_0", outstanding_cnt, 0);

    // tag 4 returns to d while being reissued to i
    d_command = LOAD; d_addr = 64'h8000; mem2proc_response = 4;
    step(); idle();
    mem2proc_tag = 4; mem2proc_data = 64'h44; push(K_D, 64'h44, 4);
    i_command = LOAD; i_addr = 64'h9000; mem2proc_response = 4;
    #2;
    chk("t6_i_response", i_response, 4);
    step(); idle();
    chk("t6_outstanding_1", outstanding_cnt, 1);
    mem2proc_tag = 4; mem2proc_data = 64'h4444; push(K_I, 64'h4444, 4);
    step(); idle();
    chk("t6_outstanding_0", outstanding_cnt, 0);

    // reset mid-flight
    d_command = LOAD; d_addr = 64'hA000; mem2proc_response = 2;
    step();
    d_addr = 64'hB000; mem2proc_response = 3;
    step(); idle();
    chk("t7_outstanding_2", outstanding_cnt, 2);
    mem2proc_tag = 2; mem2proc_data = 64'h22;
    step(); idle();
    chk("t7_pre_d_rd_valid", d_rd_valid, 1);
    chk("t7_pre_rd_data", rd_data, 64'h22);
    chk("t7_pre_rd_tag", rd_tag, 2);
    chk("t7_pre_outstanding", outstanding_cnt, 1);
    reset = 1'b0;
    #1;
    chk("t7_rst_d_rd_valid", d_rd_valid, 0);
    chk("t7_rst_rd_data", rd_data, 0);
    chk("t7_rst_rd_tag", rd_tag, 0);
    chk("t7_rst_outstanding", outstanding_cnt, 0);
    d_command = LOAD; d_addr = 64'hC000; mem2proc_response = 1;
    #1;
    chk("t7_rst_comb_d_response", d_response, 1);
    chk("t7_rst_comb_addr", proc2mem_addr, 64'hC000);
    idle();
    step();
    reset = 1'b1;
    step();
    mem2proc_tag = 3; mem2proc_data = 64'h33;
    step(); idle();
    chk("t7_stale_return_outstanding", outstanding_cnt, 0);
    chk("t7_stale_return_d_rd_valid", d_rd_valid, 0);
    repeat (2) step();

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
